// File: rtl/sbox_scheduler.sv
// sbox_scheduler
//
// Shares one pipelined masked AES S-box between two requesters. The round
// SubBytes path sends 16 bytes and the key-schedule SubWord path sends 4.
// A start latches the shared operand block. After that, one shared byte per
// cycle goes into the S-box. The key job has fixed priority, and a byte is
// issued only in a cycle where fresh randomness is available.
//
// A tag pipeline runs alongside the S-box and has the same LATENCY. Each tag
// records which requester a byte belongs to and its byte index. The result
// leaving the S-box is then written into the matching byte of that
// requester's result register.
//
// Ports:
//   ClkxCI, RstxBI          clock (rising edge); async active-low reset
//   StateStartxSI/_StatexDI  SubBytes request and shared 128-bit state
//   StateBusyxSO/DonexSO     state job busy flag and one-cycle done pulse
//   _StatexDO                shared SubBytes result (same layout as input)
//   KeyStartxSI/_KeyxDI      SubWord request and shared 32-bit word
//   KeyBusyxSO/DonexSO       key job busy flag and one-cycle done pulse
//   _KeyxDO                  shared SubWord result
//   RndValidxSI/RndReadyxSO  S-box randomness handshake
//   _SboxInxDO/_SboxOutxDI   shared byte to the S-box and shared result from it
//   ErrorxSO                 sticky randomness-underrun flag
// Share layout: byte b, share s is at bit s*W + b*8, where W is the width of
// one share (128 for the state, 32 for the key, 8 for the S-box ports).
module sbox_scheduler #(
  parameter int SHARES  = 2,
  parameter int LATENCY = 5
) (
  input  logic                  ClkxCI,
  input  logic                  RstxBI,
  input  logic                  StateStartxSI,
  input  logic [128*SHARES-1:0] _StatexDI,
  output logic                  StateBusyxSO,
  output logic                  StateDonexSO,
  output logic [128*SHARES-1:0] _StatexDO,
  input  logic                  KeyStartxSI,
  input  logic [32*SHARES-1:0]  _KeyxDI,
  output logic                  KeyBusyxSO,
  output logic                  KeyDonexSO,
  output logic [32*SHARES-1:0]  _KeyxDO,
  input  logic                  RndValidxSI,
  output logic                  RndReadyxSO,
  output logic [8*SHARES-1:0]   _SboxInxDO,
  input  logic [8*SHARES-1:0]   _SboxOutxDI,
  output logic                  ErrorxSO
);

  typedef struct packed {
    logic       valid;
    logic       src;   // 0 = state, 1 = key
    logic [3:0] idx;
  } tag_t;

  localparam logic SRC_STATE = 1'b0;
  localparam logic SRC_KEY   = 1'b1;

  // Job registers
  logic                  st_busy_q, st_done_q;
  logic [4:0]            st_iss_q, st_ret_q;
  logic [128*SHARES-1:0] st_op_q, st_res_q;
  logic                  key_busy_q, key_done_q;
  logic [2:0]            key_iss_q, key_ret_q;
  logic [32*SHARES-1:0]  key_op_q, key_res_q;
  tag_t                  tag_q [LATENCY];
  logic                  err_q, err_d;

  logic st_cand, key_cand, issue_st, issue_key;
  logic any_tag, st_ret, key_ret, st_fin, key_fin;
  tag_t tag_d, tag_out;

  assign key_cand  = key_busy_q & (key_iss_q < 3'd4);
  assign st_cand   = st_busy_q  & (st_iss_q  < 5'd16);
  assign issue_key = RndValidxSI & key_cand;
  assign issue_st  = RndValidxSI & st_cand & ~key_cand;

  // Build the tag for this cycle and select the operand byte to issue.
  // Operand shares are forwarded one by one and never XORed together.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    tag_d      = '0;
    _SboxInxDO = '0;
    if (issue_key) begin
      tag_d.valid = 1'b1;
      tag_d.src   = SRC_KEY;
      tag_d.idx   = {2'b00, key_iss_q[1:0]};
      for (int s = 0; s < SHARES; s++)
        _SboxInxDO[s*8 +: 8] = key_op_q[s*32 + 8*key_iss_q[1:0] +: 8];
    end else if (issue_st) begin
      tag_d.valid = 1'b1;
      tag_d.src   = SRC_STATE;
      tag_d.idx   = st_iss_q[3:0];
      for (int s = 0; s < SHARES; s++)
        _SboxInxDO[s*8 +: 8] = st_op_q[s*128 + 8*st_iss_q[3:0] +: 8];
    end
  end

  always_comb begin
    any_tag = 1'b0;
    for (int k = 0; k < LATENCY; k++) any_tag = any_tag | tag_q[k].valid;
  end

  assign tag_out = tag_q[LATENCY-1];
  assign st_ret  = tag_out.valid & (tag_out.src == SRC_STATE);
  assign key_ret = tag_out.valid & (tag_out.src == SRC_KEY);
  assign st_fin  = st_ret  & (st_ret_q  == 5'd15);
  assign key_fin = key_ret & (key_ret_q == 3'd3);

  // The S-box consumes randomness for every byte it is processing, so the
  // PRNG must keep supplying it until the pipeline drains. The pipeline
  // never stalls: a missing value is flagged as an error but not waited for.
  assign RndReadyxSO = issue_key | issue_st | any_tag;
  assign err_d       = err_q | (RndReadyxSO & ~RndValidxSI & any_tag);

  // Tag pipeline and error flag
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      // NOTE: the tag shift register is reset as well. Its valid bits decide
      // whether a result is written back, so stale tags must not survive a reset.
      for (int k = 0; k < LATENCY; k++) tag_q[k] <= '0;
      err_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // stage samples its predecessor's value from before this clock edge.
      tag_q[0] <= tag_d;
      for (int k = 1; k < LATENCY; k++) tag_q[k] <= tag_q[k-1];
      err_q <= err_d;
    end
  end

  // State (SubBytes) job
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      st_busy_q <= 1'b0;
      st_done_q <= 1'b0;
      st_iss_q  <= '0;
      st_ret_q  <= '0;
      st_op_q   <= '0;
      st_res_q  <= '0;
    end else begin
      st_done_q <= 1'b0;
      if (st_fin) begin
        st_busy_q <= 1'b0;
        st_done_q <= 1'b1;
        st_iss_q  <= '0;
        st_ret_q  <= '0;
      end else begin
        if (!st_busy_q && StateStartxSI) begin
          st_busy_q <= 1'b1;
          st_op_q   <= _StatexDI;
        end
        if (issue_st) st_iss_q <= st_iss_q + 5'd1;
        if (st_ret)   st_ret_q <= st_ret_q + 5'd1;
      end
      if (st_ret)
        for (int s = 0; s < SHARES; s++)
          st_res_q[s*128 + 8*tag_out.idx +: 8] <= _SboxOutxDI[s*8 +: 8];
    end
  end

  // Key (SubWord) job
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      key_busy_q <= 1'b0;
      key_done_q <= 1'b0;
      key_iss_q  <= '0;
      key_ret_q  <= '0;
      key_op_q   <= '0;
      key_res_q  <= '0;
    end else begin
      key_done_q <= 1'b0;
      if (key_fin) begin
        key_busy_q <= 1'b0;
        key_done_q <= 1'b1;
        key_iss_q  <= '0;
        key_ret_q  <= '0;
      end else begin
        if (!key_busy_q && KeyStartxSI) begin
          key_busy_q <= 1'b1;
          key_op_q   <= _KeyxDI;
        end
        if (issue_key) key_iss_q <= key_iss_q + 3'd1;
        if (key_ret)   key_ret_q <= key_ret_q + 3'd1;
      end
      if (key_ret)
        for (int s = 0; s < SHARES; s++)
          key_res_q[s*32 + 8*tag_out.idx[1:0] +: 8] <= _SboxOutxDI[s*8 +: 8];
    end
  end

  assign StateBusyxSO = st_busy_q;
  assign StateDonexSO = st_done_q;
  assign _StatexDO    = st_res_q;
  assign KeyBusyxSO   = key_busy_q;
  assign KeyDonexSO   = key_done_q;
  assign _KeyxDO      = key_res_q;
  assign ErrorxSO     = err_q;

endmodule

// File: tb/tb_sbox_scheduler.sv
// Testbench for sbox_scheduler with SHARES = 2 and LATENCY = 5.
// The S-box is modelled here as a 5-deep pipeline. Each cycle it recombines
// the input shares, looks the value up in an AES S-box table built from the
// GF(2^8) definition, and splits the result again with a fresh random mask.
// Expected results are hand-computed AES S-box values.
module tb_sbox_scheduler;
  localparam int SHARES  = 2;
  localparam int LATENCY = 5;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  st_start = 1'b0, key_start = 1'b0, rnd_valid = 1'b1;
  logic [128*SHARES-1:0] st_in = '0, st_out;
  logic [32*SHARES-1:0]  key_in = '0, key_out;
  logic                  st_busy, st_done, key_busy, key_done, rnd_ready, err;
  logic [8*SHARES-1:0]   sbox_in, sbox_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sbox_scheduler #(.SHARES(SHARES), .LATENCY(LATENCY)) dut (
    .ClkxCI(clk), .RstxBI(rst_n),
    .StateStartxSI(st_start), ._StatexDI(st_in),
    .StateBusyxSO(st_busy), .StateDonexSO(st_done), ._StatexDO(st_out),
    .KeyStartxSI(key_start), ._KeyxDI(key_in),
    .KeyBusyxSO(key_busy), .KeyDonexSO(key_done), ._KeyxDO(key_out),
    .RndValidxSI(rnd_valid), .RndReadyxSO(rnd_ready),
    ._SboxInxDO(sbox_in), ._SboxOutxDI(sbox_out),
    .ErrorxSO(err)
  );

  // ---------------- S-box reference model ----------------
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                  ^ rotl(inv, 4) ^ 8'h63;
    end
  end

  logic [8*SHARES-1:0] pipe [LATENCY];
  always @(posedge clk) begin : sbox_model
    logic [7:0] x, m;
    x = sbox_in[7:0] ^ sbox_in[15:8];
    m = 8'($urandom);
    pipe[0] <= {m, sbox_tab[x] ^ m};
    for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
  end
  assign sbox_out = pipe[LATENCY-1];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_state(input logic [127:0] plain, input logic [127:0] mask);
    st_in = {mask, plain ^ mask};
  endtask

  task automatic load_key(input logic [31:0] plain, input logic [31:0] mask);
    key_in = {mask, plain ^ mask};
  endtask

  // Starts the requested jobs and then watches 40 cycles. Cycle 0 is the
  // first cycle after the start edge. rnd_low bit c holds RndValid low in
  // cycle c. A key job with key_at > 0 is started so that its cycle 0 is
  // cycle key_at of the run. The task returns the first done cycle (-1 if
  // none) and the number of cycles in which done was high.
  task automatic run(input bit do_st, input bit do_key, input int key_at,
                     input logic [63:0] rnd_low,
                     output int st_c, output int key_c,
                     output int st_n, output int key_n);
    st_c = -1; key_c = -1; st_n = 0; key_n = 0;
    st_start  = do_st;
    key_start = do_key && (key_at == 0);
    step();
    st_start  = 1'b0;
    key_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      rnd_valid = ~rnd_low[c];
      key_start = do_key && (key_at > 0) && (c == key_at - 1);
      if (st_done)  begin st_n++;  if (st_c  < 0) st_c  = c; end
      if (key_done) begin key_n++; if (key_c < 0) key_c = c; end
      step();
    end
    key_start = 1'b0;
    rnd_valid = 1'b1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    string        name;
    logic         is_key;
    logic [127:0] plain;
    logic [127:0] mask;
    logic [127:0] exp_v;
    logic [63:0]  rnd_low;
    int           done_cyc;
    logic         exp_err;
  } vec_t;

  localparam logic [127:0] P_A = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] S_A = 128'h76abd7fe2b670130c56f6bf27b777c63;
  localparam logic [127:0] P_B = 128'h1f1e1d1c1b1a19181716151413121110;
  localparam logic [127:0] S_B = 128'hc072a49cafa2d4adf04759fa7dc982ca;
  localparam logic [127:0] M_1 = 128'h3a91c4e7205bd8f61e7fa2c8945d0b33;
  localparam logic [31:0]  P_K1 = 32'hff530100, S_K1 = 32'h16ed7c63;
  localparam logic [31:0]  P_K2 = 32'h1110fef0, S_K2 = 32'h82cabb8c;
  localparam logic [31:0]  M_K  = 32'h3c5a96e1;

  vec_t vecs [7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int sc, kc, sn, kn;
    logic seen;

    vecs[0] = '{"st_seq",      1'b0, P_A,   M_1,   S_A, 64'h0, 21, 1'b0};
    vecs[1] = '{"st_zero_53",  1'b0, '0, {16{8'h53}}, {16{8'h63}}, 64'h0, 21, 1'b0};
    vecs[2] = '{"st_seq_b",    1'b0, P_B,   ~M_1,  S_B, 64'h0, 21, 1'b0};
    vecs[3] = '{"key_k1",      1'b1, {96'h0, P_K1}, {96'h0, M_K},  {96'h0, S_K1}, 64'h0, 9, 1'b0};
    vecs[4] = '{"key_k2",      1'b1, {96'h0, P_K2}, {96'h0, ~M_K}, {96'h0, S_K2}, 64'h0, 9, 1'b0};
    vecs[5] = '{"st_rnd_wait", 1'b0, P_A,   M_1,   S_A, 64'h7, 24, 1'b0};
    vecs[6] = '{"st_rnd_drop", 1'b0, P_B,   M_1,   S_B, 64'h80, 22, 1'b1};

    // Reset values
    #1 rst_n = 1'b0;
    #11;
    check("rst_st_busy",  st_busy,   1'b0);
    check("rst_st_done",  st_done,   1'b0);
    check("rst_key_busy", key_busy,  1'b0);
    check("rst_key_done", key_done,  1'b0);
    check("rst_st_out",   st_out[127:0] | st_out[255:128], '0);
    check("rst_key_out",  key_out,   '0);
    check("rst_ready",    rnd_ready, 1'b0);
    check("rst_sbox_in",  sbox_in,   '0);
    check("rst_err",      err,       1'b0);
    step();
    rst_n = 1'b1;
    step();

    // Simultaneous starts: key issues first, state follows
    load_state(P_A, M_1);
    load_key(P_K1, M_K);
    run(1'b1, 1'b1, 0, 64'h0, sc, kc, sn, kn);
    check("sim_key_cyc",  kc, 9);
    check("sim_st_cyc",   sc, 25);
    check("sim_pulses",   {sn[7:0], kn[7:0]}, 16'h0101);
    check("sim_key_res",  key_out[31:0] ^ key_out[63:32], S_K1);
    check("sim_st_res",   st_out[127:0] ^ st_out[255:128], S_A);

    // Key start in state cycle 5 preempts state issue for 4 cycles
    load_state(P_B, M_1);
    load_key(P_K2, M_K);
    run(1'b1, 1'b1, 6, 64'h0, sc, kc, sn, kn);
    check("pre_key_cyc", kc, 15);
    check("pre_st_cyc",  sc, 25);
    check("pre_key_res", key_out[31:0] ^ key_out[63:32], S_K2);
    check("pre_st_res",  st_out[127:0] ^ st_out[255:128], S_B);
    check("pre_err",     err, 1'b0);

    // Table-driven single-job vectors
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_key) begin
        load_key(vecs[i].plain[31:0], vecs[i].mask[31:0]);
        run(1'b0, 1'b1, 0, vecs[i].rnd_low, sc, kc, sn, kn);
        check({vecs[i].name, "_cyc"},   kc, vecs[i].done_cyc);
        check({vecs[i].name, "_pulse"}, kn, 1);
        check({vecs[i].name, "_busy"},  key_busy, 1'b0);
        check({vecs[i].name, "_res"},   key_out[31:0] ^ key_out[63:32], vecs[i].exp_v);
      end else begin
        load_state(vecs[i].plain, vecs[i].mask);
        run(1'b1, 1'b0, 0, vecs[i].rnd_low, sc, kc, sn, kn);
        check({vecs[i].name, "_cyc"},   sc, vecs[i].done_cyc);
        check({vecs[i].name, "_pulse"}, sn, 1);
        check({vecs[i].name, "_busy"},  st_busy, 1'b0);
        check({vecs[i].name, "_res"},   st_out[127:0] ^ st_out[255:128], vecs[i].exp_v);
      end
      check({vecs[i].name, "_err"}, err, vecs[i].exp_err);
    end

    // The error flag stays set
    repeat (3) step();
    check("err_sticky", err, 1'b1);

    // Reset in cycle 10 of a state job
    load_state(P_A, M_1);
    st_start = 1'b1;
    step();
    st_start = 1'b0;
    repeat (10) step();
    check("mid_partial", |(st_out[127:0] ^ st_out[255:128]), 1'b1);
    rst_n = 1'b0;
    #1;
    check("mrst_st_busy", st_busy,   1'b0);
    check("mrst_st_out",  st_out[127:0] | st_out[255:128], '0);
    check("mrst_key_out", key_out,   '0);
    check("mrst_ready",   rnd_ready, 1'b0);
    check("mrst_sbox_in", sbox_in,   '0);
    check("mrst_err",     err,       1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen = seen | (|st_out) | st_busy | st_done;
      step();
    end
    check("post_rst_quiet", seen, 1'b0);

    // A new job after the reset completes normally
    load_state(P_B, ~M_1);
    run(1'b1, 1'b0, 0, 64'h0, sc, kc, sn, kn);
    check("post_rst_cyc", sc, 21);
    check("post_rst_res", st_out[127:0] ^ st_out[255:128], S_B);
    check("post_rst_err", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
